freq_meter: RTL and testbench

Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of clk_100MHz cycles (1 s by default) and presents the result as packed BCD digits for the 7-segment display path. It sits between an asynchronous input pin and the display multiplexer. It is the counting counterpart of the 1 Hz divider: one generates a known rate, this block measures an unknown one.

---
 rtl/freq_meter.sv | 161 ++++++++++++++++
 tb/tb_freq_meter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and publishes the count as saturating packed BCD.
// Latency: first result GATE_CYCLES+3 cycles after en is sampled high; then one result every GATE_CYCLES cycles.
// Backpressure: none; valid is a one-cycle pulse and the result registers hold until the next completed window.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int DIGITS      = 4
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  overflow,
    output logic                  valid,
    output logic                  gate_active
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int BW = 4 * DIGITS;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    warm_cnt;
    logic [GW-1:0] gate_cnt;
    logic [BW-1:0] acc;
    logic          ovf_acc;

    logic          s1, s2, s3;
    logic          sig_edge;

    logic [BW:0]   inc_res;
    logic [BW-1:0] acc_next;
    logic          ovf_next;

    // BCD +1 with ripple carry; if every digit is 9 the value holds and bit BW flags the saturation.
    function automatic logic [BW:0] bcd_inc(input logic [BW-1:0] a);
        logic [BW-1:0] r;
        logic          all9;
        logic          carry;
        r     = a;
        all9  = 1'b1;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[4*d +: 4] != 4'd9) all9 = 1'b0;
        end
        if (all9) begin
            return {1'b1, a};
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (a[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = a[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {1'b0, r};
    endfunction

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 & ~s3;
    assign inc_res  = bcd_inc(acc);

    // Accumulator value including this cycle's edge, shared by counting and the terminal publish.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf_acc;
        if (sig_edge) begin
            acc_next = inc_res[BW-1:0];
            ovf_next = ovf_acc | inc_res[BW];
        end
    end

    // Measurement FSM: warm up the synchronizer, then run back-to-back gate windows while en stays high.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            warm_cnt    <= 2'd0;
            gate_cnt    <= '0;
            acc         <= '0;
            ovf_acc     <= 1'b0;
            freq_bcd    <= '0;
            overflow    <= 1'b0;
            valid       <= 1'b0;
            gate_active <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    warm_cnt <= 2'd0;
                    gate_cnt <= '0;
                    acc      <= '0;
                    ovf_acc  <= 1'b0;
                    if (en) state <= WARMUP;
                end
                WARMUP: begin
                    if (!en) begin
                        state    <= IDLE;
                        warm_cnt <= 2'd0;
                    end else if (warm_cnt == 2'd2) begin
                        state       <= MEASURE;
                        gate_active <= 1'b1;
                        warm_cnt    <= 2'd0;
                    end else begin
                        warm_cnt <= warm_cnt + 2'd1;
                    end
                end
                MEASURE: begin
                    if (gate_cnt == GATE_LAST) begin
                        // Publish even if en drops on this edge; only the next window is abandoned.
                        freq_bcd <= acc_next;
                        overflow <= ovf_next;
                        valid    <= 1'b1;
                        acc      <= '0;
                        ovf_acc  <= 1'b0;
                        gate_cnt <= '0;
                        if (!en) begin
                            state       <= IDLE;
                            gate_active <= 1'b0;
                        end
                    end else if (!en) begin
                        state       <= IDLE;
                        gate_active <= 1'b0;
                        gate_cnt    <= '0;
                        acc         <= '0;
                        ovf_acc     <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        acc      <= acc_next;
                        ovf_acc  <= ovf_next;
                    end
                end
                default: begin
                    state       <= IDLE;
                    gate_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 4-digit and a 1-digit instance share stimulus with a 100-cycle gate.
// Expected results (cycle of valid, digits, overflow) are queued by the stimulus and popped by a negedge monitor.
// Covers reset, steady counts, BCD carry, saturation and recovery, static input, abort, en low at terminal, mid-window reset.
module tb_freq_meter;

    localparam int G = 100;

    logic        clk_100MHz = 1'b0;
    logic        rst_n      = 1'b0;
    logic        en         = 1'b0;
    logic        sig_in     = 1'b0;

    logic [15:0] freq4;
    logic        ovf4, valid4, ga4;
    logic [3:0]  freq1;
    logic        ovf1, valid1, ga1;

    always #5 clk_100MHz = ~clk_100MHz;

    freq_meter #(.GATE_CYCLES(G), .DIGITS(4)) u_dut4 (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .freq_bcd   (freq4),
        .overflow   (ovf4),
        .valid      (valid4),
        .gate_active(ga4)
    );

    freq_meter #(.GATE_CYCLES(G), .DIGITS(1)) u_dut1 (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .freq_bcd   (freq1),
        .overflow   (ovf1),
        .valid      (valid1),
        .gate_active(ga1)
    );

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic        ovf;
        logic        chk4;
        logic [3:0]  bcd1;
        logic        ovf1;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Signal generator state: static level or square wave with half-period hp.
    logic sig_mode = 1'b0;
    logic sig_lvl  = 1'b0;
    int   hp       = 5;
    int   ph       = 0;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int at, input logic [15:0] b, input logic o,
                        input logic c4, input logic [3:0] b1, input logic o1);
        exp_t e;
        e.cyc  = at;
        e.bcd  = b;
        e.ovf  = o;
        e.chk4 = c4;
        e.bcd1 = b1;
        e.ovf1 = o1;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_100MHz);
    endtask

    task automatic set_period(input int h);
        hp       = h;
        ph       = 0;
        sig_mode = 1'b1;
    endtask

    task automatic set_static(input logic l);
        sig_lvl  = l;
        sig_mode = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk_100MHz);
            #1;
            if (sig_mode) begin
                sig_in = (ph < hp);
                ph     = (ph + 1 >= 2 * hp) ? 0 : ph + 1;
            end else begin
                sig_in = sig_lvl;
            end
        end
    end

    // Monitor: every valid pulse must match the head of the scoreboard, including the exact cycle.
    always @(negedge clk_100MHz) begin : mon
        exp_t e;
        if (valid4 || valid1) begin
            chk("valid_pair", {31'd0, valid1}, {31'd0, valid4});
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid cyc=%0d actual=1 expected=0", cyc);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                if (e.chk4) begin
                    chk("freq_bcd4", {16'd0, freq4}, {16'd0, e.bcd});
                    chk("overflow4", {31'd0, ovf4}, {31'd0, e.ovf});
                end
                chk("freq_bcd1", {28'd0, freq1}, {28'd0, e.bcd1});
                chk("overflow1", {31'd0, ovf1}, {31'd0, e.ovf1});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;

        // Reset held with en high and sig toggling: all outputs stay zero.
        en = 1'b1;
        set_period(5);
        repeat (10) begin
            @(negedge clk_100MHz);
            chk("reset_outputs", {6'd0, freq4, ovf4, valid4, ga4, freq1, ovf1, valid1, ga1}, 32'd0);
        end

        // Release: first valid GATE+3 cycles after the edge that samples en; then every G cycles.
        c     = cyc;
        rst_n = 1'b1;
        push(c + 104, 16'h0010, 1'b0, 1'b1, 4'h9, 1'b1);
        push(c + 204, 16'h0010, 1'b0, 1'b1, 4'h9, 1'b1);
        push(c + 304, 16'h0010, 1'b0, 1'b1, 4'h9, 1'b1);
        wait_to(c + 3);
        chk("gate_warmup_low", {31'd0, ga4}, 32'd0);
        wait_to(c + 4);
        chk("gate_measure_high", {31'd0, ga4}, 32'd1);

        // Abort at gate count ~50: no valid, result retained, gate_active falls next cycle.
        wait_to(c + 354);
        chk("abort_gate_before", {31'd0, ga4}, 32'd1);
        en = 1'b0;
        @(negedge clk_100MHz);
        chk("abort_gate_after", {31'd0, ga4}, 32'd0);
        chk("abort_keep_bcd4", {16'd0, freq4}, 32'h0010);
        chk("abort_keep_ovf4", {31'd0, ovf4}, 32'd0);
        chk("abort_keep_bcd1", {28'd0, freq1}, 32'h9);
        repeat (20) @(negedge clk_100MHz);
        chk("abort_queue", sb.size(), 32'd0);

        // Re-raise en with period 4: 25 edges, then freeze, then an all-static window clears overflow.
        set_period(2);
        repeat (10) @(negedge clk_100MHz);
        c  = cyc;
        en = 1'b1;
        push(c + 104, 16'h0025, 1'b0, 1'b1, 4'h9, 1'b1);
        push(c + 204, 16'h0000, 1'b0, 1'b0, 4'h9, 1'b1);
        push(c + 304, 16'h0000, 1'b0, 1'b1, 4'h0, 1'b0);
        wait_to(c + 194);
        set_static(1'b0);
        wait_to(c + 305);
        en = 1'b0;
        repeat (5) @(negedge clk_100MHz);

        // Input held high before and during measurement: no spurious edge.
        set_static(1'b1);
        repeat (10) @(negedge clk_100MHz);
        c  = cyc;
        en = 1'b1;
        push(c + 104, 16'h0000, 1'b0, 1'b1, 4'h0, 1'b0);
        push(c + 204, 16'h0000, 1'b0, 1'b1, 4'h0, 1'b0);
        wait_to(c + 205);
        en = 1'b0;
        repeat (5) @(negedge clk_100MHz);

        // en falls exactly at the publish edge: result still published, then idle.
        set_period(5);
        repeat (10) @(negedge clk_100MHz);
        c  = cyc;
        en = 1'b1;
        push(c + 104, 16'h0010, 1'b0, 1'b1, 4'h9, 1'b1);
        wait_to(c + 103);
        en = 1'b0;
        wait_to(c + 104);
        chk("terminal_gate_low", {31'd0, ga4}, 32'd0);
        wait_to(c + 130);
        chk("terminal_queue", sb.size(), 32'd0);

        // Asynchronous reset mid-window clears everything at once and publishes nothing.
        c  = cyc;
        en = 1'b1;
        wait_to(c + 60);
        chk("pre_reset_bcd4", {16'd0, freq4}, 32'h0010);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {6'd0, freq4, ovf4, valid4, ga4, freq1, ovf1, valid1, ga1}, 32'd0);
        @(negedge clk_100MHz);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk_100MHz);
        chk("post_reset_bcd4", {16'd0, freq4}, 32'd0);
        chk("final_queue", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
